// File: rtl/controle_tranca_if.sv
// Lock controller bus: detector indications and alarm acknowledge in, lock/panel status out.
interface controle_tranca_if #(
    parameter int unsigned MAX_FAIL = 3
);
    localparam int unsigned FW = $clog2(MAX_FAIL + 1);

    logic          s1;
    logic          s2;
    logic          alarm_ack;
    logic          unlock;
    logic          lockout;
    logic          alarm;
    logic          led;
    logic [FW-1:0] fail_cnt;

    modport master (
        output s1, s2, alarm_ack,
        input  unlock, lockout, alarm, led, fail_cnt
    );

    modport slave (
        input  s1, s2, alarm_ack,
        output unlock, lockout, alarm, led, fail_cnt
    );
endinterface

// File: rtl/controle_tranca.sv
// Lock controller behind the code detector: timed unlock, failure counting, timed lockout with blinking LED.
// Optional CTRL_STICKY_ALARM_EN keeps alarm set after lockout until alarm_ack outside LOCKOUT.
module controle_tranca #(
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned OPEN_CYCLES = 8,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned BLINK_DIV   = 2
) (
    input logic             clk,
    input logic             rst,
    controle_tranca_if.slave bus
);
    localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
    localparam int unsigned MAXC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, OPEN, LOCKOUT} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [BW-1:0] blink, blink_nx;
    logic [FW-1:0] fail, fail_nx;
    logic          unlock_q, unlock_nx;
    logic          lockout_q, lockout_nx;
    logic          alarm_q, alarm_nx;
    logic          led_q, led_nx;
    logic          s1_q, s2_q;
    logic          ok_evt_c, err_evt_c;

    // Rising edges only; a simultaneous wrong code wins over a correct one
    assign err_evt_c = bus.s2 & ~s2_q;
    assign ok_evt_c  = bus.s1 & ~s1_q & ~err_evt_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        blink_nx   = blink;
        fail_nx    = fail;
        unlock_nx  = unlock_q;
        lockout_nx = lockout_q;
        led_nx     = led_q;
        alarm_nx   = alarm_q;

        case (state)
            IDLE: begin
                if (err_evt_c) begin
                    if (32'(fail) + 32'd1 < MAX_FAIL) begin
                        fail_nx = FW'(fail + 1'b1);
                    end else begin
                        state_nx   = LOCKOUT;
                        fail_nx    = FW'(MAX_FAIL);
                        timer_nx   = TW'(LOCK_CYCLES - 1);
                        blink_nx   = '0;
                        led_nx     = 1'b1;
                        lockout_nx = 1'b1;
                    end
                end else if (ok_evt_c) begin
                    state_nx  = OPEN;
                    timer_nx  = TW'(OPEN_CYCLES - 1);
                    fail_nx   = '0;
                    unlock_nx = 1'b1;
                    led_nx    = 1'b1;
                end
            end
            OPEN: begin
                if (ok_evt_c) begin
                    timer_nx = TW'(OPEN_CYCLES - 1);
                end else if (timer == '0) begin
                    state_nx  = IDLE;
                    unlock_nx = 1'b0;
                    led_nx    = 1'b0;
                end else begin
                    timer_nx = TW'(timer - 1'b1);
                end
            end
            LOCKOUT: begin
                if (timer == '0) begin
                    state_nx   = IDLE;
                    fail_nx    = '0;
                    led_nx     = 1'b0;
                    lockout_nx = 1'b0;
                    blink_nx   = '0;
                end else begin
                    timer_nx = TW'(timer - 1'b1);
                    if (blink == BW'(BLINK_DIV - 1)) begin
                        led_nx   = ~led_q;
                        blink_nx = '0;
                    end else begin
                        blink_nx = BW'(blink + 1'b1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

`ifdef CTRL_STICKY_ALARM_EN
        if (state != LOCKOUT && bus.alarm_ack) alarm_nx = 1'b0;
        if (state != LOCKOUT && state_nx == LOCKOUT) alarm_nx = 1'b1;
`else
        alarm_nx = lockout_nx;
`endif
    end

`ifndef CTRL_STICKY_ALARM_EN
    logic unused_alarm_ack;
    assign unused_alarm_ack = bus.alarm_ack;
`endif

    // Edge registers reset high so a level already present at reset release is not an event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer     <= '0;
            blink     <= '0;
            fail      <= '0;
            unlock_q  <= 1'b0;
            lockout_q <= 1'b0;
            alarm_q   <= 1'b0;
            led_q     <= 1'b0;
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
        end else begin
            timer     <= timer_nx;
            blink     <= blink_nx;
            fail      <= fail_nx;
            unlock_q  <= unlock_nx;
            lockout_q <= lockout_nx;
            alarm_q   <= alarm_nx;
            led_q     <= led_nx;
            s1_q      <= bus.s1;
            s2_q      <= bus.s2;
        end
    end

    assign bus.unlock   = unlock_q;
    assign bus.lockout  = lockout_q;
    assign bus.alarm    = alarm_q;
    assign bus.led      = led_q;
    assign bus.fail_cnt = fail;
endmodule

// File: tb/tb_controle_tranca.sv
// Directed bench for controle_tranca; honours CTRL_STICKY_ALARM_EN when defined.
module tb_controle_tranca;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    controle_tranca_if #(.MAX_FAIL(3)) bus ();

    controle_tranca #(
        .MAX_FAIL(3), .OPEN_CYCLES(8), .LOCK_CYCLES(16), .BLINK_DIV(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_s1();
        bus.s1 = 1'b1;
        tick();
        bus.s1 = 1'b0;
    endtask

    task automatic pulse_s2();
        bus.s2 = 1'b1;
        tick();
        bus.s2 = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_unlock"},  32'(bus.unlock),   32'd0);
        check({tag, "_lockout"}, 32'(bus.lockout),  32'd0);
        check({tag, "_led"},     32'(bus.led),      32'd0);
        check({tag, "_fail"},    32'(bus.fail_cnt), 32'd0);
    endtask

    // Counts unlock-high cycles from the current sample on, bounded
    task automatic count_unlock(input int start, output int cnt);
        cnt = start;
        for (int g = 0; g < 40 && bus.unlock; g++) begin
            tick();
            if (bus.unlock) cnt++;
        end
    endtask

    // Three separated wrong codes; returns sampled right after lockout entry
    task automatic enter_lockout();
        pulse_s2(); tick();
        pulse_s2(); tick();
        pulse_s2();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        rst = 1'b1;
        bus.s1 = 1'b0;
        bus.s2 = 1'b0;
        bus.alarm_ack = 1'b0;
        #12;
        check_idle("reset");
        check("reset_alarm", 32'(bus.alarm), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(); tick();

        // Correct code: 8-cycle unlock
        pulse_s1();
        for (int i = 0; i < 8; i++) begin
            check("open_unlock", 32'(bus.unlock),   32'd1);
            check("open_led",    32'(bus.led),      32'd1);
            check("open_fail",   32'(bus.fail_cnt), 32'd0);
            tick();
        end
        check_idle("open_end");

        // Lockout after three wrong codes
        pulse_s2();
        check("err1_fail", 32'(bus.fail_cnt), 32'd1);
        check("err1_lockout", 32'(bus.lockout), 32'd0);
        tick();
        pulse_s2();
        check("err2_fail", 32'(bus.fail_cnt), 32'd2);
        tick();
        pulse_s2();
        check("lock_fail", 32'(bus.fail_cnt), 32'd3);
        for (int k = 0; k < 16; k++) begin
            check("lock_lockout", 32'(bus.lockout), 32'd1);
            check("lock_alarm",   32'(bus.alarm),   32'd1);
            check("lock_unlock",  32'(bus.unlock),  32'd0);
            check("lock_led",     32'(bus.led),     ((k / 2) % 2 == 0) ? 32'd1 : 32'd0);
            bus.s1 = (k == 4);
            bus.alarm_ack = (k == 8);
            tick();
        end
        bus.s1 = 1'b0;
        bus.alarm_ack = 1'b0;
        check_idle("lock_end");
`ifdef CTRL_STICKY_ALARM_EN
        check("sticky_hold", 32'(bus.alarm), 32'd1);
        tick();
        check("sticky_hold2", 32'(bus.alarm), 32'd1);
        bus.alarm_ack = 1'b1;
        tick();
        bus.alarm_ack = 1'b0;
        check("sticky_ack", 32'(bus.alarm), 32'd0);
`else
        check("lock_end_alarm", 32'(bus.alarm), 32'd0);
`endif
        tick();
        check("no_stale_unlock", 32'(bus.unlock), 32'd0);

        // Recovery: two failures then correct code
        pulse_s2(); tick();
        pulse_s2();
        check("rec_fail2", 32'(bus.fail_cnt), 32'd2);
        tick();
        pulse_s1();
        check("rec_fail0", 32'(bus.fail_cnt), 32'd0);
        count_unlock(1, cnt);
        check("rec_open_len", 32'(cnt), 32'd8);
        tick();

        // Simultaneous rise counts as wrong code
        bus.s1 = 1'b1;
        bus.s2 = 1'b1;
        tick();
        bus.s1 = 1'b0;
        bus.s2 = 1'b0;
        check("simul_fail", 32'(bus.fail_cnt), 32'd1);
        check("simul_unlock", 32'(bus.unlock), 32'd0);
        tick();
        pulse_s1();
        count_unlock(1, cnt);
        check("simul_clear_len", 32'(cnt), 32'd8);
        check("simul_clear_fail", 32'(bus.fail_cnt), 32'd0);

        // Held s1 gives one window
        bus.s1 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.unlock) cnt++;
        end
        check("held_len", 32'(cnt), 32'd8);
        check("held_end", 32'(bus.unlock), 32'd0);
        bus.s1 = 1'b0;
        tick();

        // Re-pulse after 5 open cycles extends the window
        pulse_s1();
        cnt = 1;
        for (int i = 1; i < 5; i++) begin
            tick();
            if (bus.unlock) cnt++;
        end
        pulse_s1();
        if (bus.unlock) cnt++;
        count_unlock(cnt, cnt);
        check("extend_len", 32'(cnt), 32'd13);
        tick();

        // Async reset in lockout cycle 7 with s2 held through release
        enter_lockout();
        check("rst_pre_lockout", 32'(bus.lockout), 32'd1);
        for (int i = 0; i < 6; i++) tick();
        bus.s2 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_idle("rst_async");
        check("rst_async_alarm", 32'(bus.alarm), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(); tick();
        check("rst_held_s2_fail", 32'(bus.fail_cnt), 32'd0);
        check("rst_held_s2_lock", 32'(bus.lockout), 32'd0);
        bus.s2 = 1'b0;
        tick();
        pulse_s2();
        check("rst_after_fail", 32'(bus.fail_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/controle_tranca.md
Name: controle_tranca

Overview:
- Lock controller placed directly downstream of the code-sequence detector (`detecta`).
- Consumes the detector's "code correct" (s1) and "code wrong" (s2) indications.
- Drives a timed unlock output, counts consecutive failed attempts and enforces a timed lockout after too many failures.
- Drives the panel LED: off when idle, steady when open, blinking during lockout.

Parameters:
- MAX_FAIL, 3, consecutive wrong codes that trigger lockout (>=1).
- OPEN_CYCLES, 8, clock cycles unlock stays high per correct code (>=1).
- LOCK_CYCLES, 16, clock cycles of lockout (>=1).
- BLINK_DIV, 2, led toggle period in cycles during lockout (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- s1  input  1  code-correct indication from detector (level or pulse).
- s2  input  1  code-wrong indication from detector (level or pulse).
- alarm_ack  input  1  clears sticky alarm (used only with CTRL_STICKY_ALARM_EN).
- unlock  output  1  lock released.
- lockout  output  1  lockout active; inputs ignored.
- alarm  output  1  alarm indication.
- led  output  1  panel LED.
- fail_cnt  output  $clog2(MAX_FAIL+1)  current consecutive failures.

Behaviour:
- Reset (async, rst=1): state IDLE; unlock=0, lockout=0, alarm=0, led=0, fail_cnt=0, timers=0, blink counter=0.
- Reset edge registers: s1_q and s2_q reset to 1, so a level already high at reset release is not an event.
- Reset mid-operation: reset takes effect immediately in any state; an OPEN or LOCKOUT in progress is aborted.
- Event detection: ok_evt = s1 & ~s1_q; err_evt = s2 & ~s2_q. Both are rising edges, sampled every clk.
- A held-high level counts once.
- If ok_evt and err_evt occur in the same cycle, the cycle is treated as err_evt only.
- All outputs are registered. The response appears after the same rising edge that first samples the input high (latency 1 edge).
- Timer width is $clog2(max(OPEN_CYCLES, LOCK_CYCLES)).
- State IDLE:
  - ok_evt -> OPEN; timer <= OPEN_CYCLES-1; fail_cnt <= 0.
  - err_evt with fail_cnt+1 < MAX_FAIL -> stay IDLE; fail_cnt <= fail_cnt+1.
  - err_evt with fail_cnt+1 == MAX_FAIL -> LOCKOUT; fail_cnt <= MAX_FAIL; timer <= LOCK_CYCLES-1; blink counter cleared; led <= 1.
- State OPEN:
  - unlock=1 and led=1 for exactly OPEN_CYCLES cycles; timer decrements each cycle.
  - At timer==0 -> IDLE; unlock and led return to 0.
  - ok_evt reloads timer to OPEN_CYCLES-1 (extends the open window).
  - err_evt is ignored and does not change fail_cnt.
- State LOCKOUT:
  - lockout=1 and alarm=1 for exactly LOCK_CYCLES cycles.
  - All events are ignored; edge registers still track the inputs, so no stale event fires on exit.
  - led toggles every BLINK_DIV cycles, starting at 1.
  - At timer==0 -> IDLE; fail_cnt <= 0; led <= 0; lockout <= 0.
- fail_cnt saturates at MAX_FAIL and never wraps.
- unlock and lockout are never high simultaneously.

Optional Feature:
- Macro: CTRL_STICKY_ALARM_EN.
- Defined:
  - alarm sets on LOCKOUT entry and stays 1 after lockout ends.
  - alarm clears only on a cycle with alarm_ack=1 while not in LOCKOUT.
  - alarm_ack during LOCKOUT is ignored.
  - While alarm is sticky high, IDLE/OPEN operation proceeds normally.
- Undefined:
  - alarm == lockout.
  - alarm_ack is unused.

Test Plan:
- Correct code: rst pulse, then s1 high 1 cycle -> unlock=1, led=1 for exactly 8 cycles, then 0; fail_cnt=0 throughout.
- Lockout: three s2 pulses, separated by low cycles:
  - fail_cnt goes 1, 2, then lockout=1 and alarm=1 for 16 cycles.
  - led toggles every 2 cycles.
  - An s1 pulse during lockout is ignored (unlock stays 0).
  - After lockout: fail_cnt=0, all outputs 0.
- Recovery: two s2 pulses then s1 -> fail_cnt 2 then 0; unlock high for 8 cycles.
- Simultaneous/held inputs:
  - s1 and s2 rising in the same cycle -> fail_cnt+1, unlock stays 0.
  - s1 held high for 20 cycles -> single 8-cycle unlock.
  - s1 re-pulsed at cycle 5 of OPEN -> unlock lasts 5+8 cycles total.
- Reset mid-lockout: assert rst asynchronously at lockout cycle 7 -> all outputs 0 immediately; s2 held high through reset release produces no event.
- CTRL_STICKY_ALARM_EN defined: after the 16-cycle lockout, alarm stays 1; alarm_ack=1 for one cycle -> alarm=0 after the next edge; alarm_ack during lockout has no effect.
